// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction prefetcher.
package fetch_pkg;

   localparam int unsigned DEPTH_DEF = 4;
   localparam int unsigned AW_DEF    = 14;

   // Buffered addresses are held at full word-address width. Narrower AW values
   // are zero-extended, so one entry type serves every AW.
   localparam int unsigned ENTRY_AW = 30;
   localparam int unsigned DW       = 32;

   typedef enum logic [0:0] {
      IDLE,
      STREAM
   } fetch_state_e;

   typedef struct packed {
      logic [ENTRY_AW-1:0] addr;
      logic [DW-1:0]       data;
   } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Entry FIFO holding prefetched {word address, instruction} pairs in fetch order.
module prefetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         push_i,
   input  fetch_entry_t                 push_entry_i,
   input  logic                         pop_i,
   input  logic                         flush_i,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output fetch_entry_t                 head_o,
   output logic                         full_o,
   output logic                         empty_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   // Pointer and occupancy update; flush wins over push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   // Control state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are only meaningful below count_q, so no reset.
   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) begin
         mem_q[wr_ptr_q] <= push_entry_i;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/instr_prefetch.sv
// Sequential instruction prefetcher between a CPU fetch port and a 1-cycle SRAM.
// Hits come from the FIFO head or from the in-flight SRAM response (bypass);
// anything else flushes and restarts the stream at the requested address.
module instr_prefetch
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned AW    = AW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic [31:0]   cpu_addr,
   output logic          cpu_valid,
   output logic [31:0]   cpu_instr,
   output logic          mem_read,
   output logic [AW-1:0] mem_addr,
   input  logic [31:0]   mem_dout
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   fetch_state_e  state_q, state_d;
   logic          inflight_q, inflight_d;
   logic [AW-1:0] if_addr_q, if_addr_d;
   logic [AW-1:0] pf_addr_q, pf_addr_d;

   logic [AW-1:0] cpu_word;
   logic          unused_cpu_addr_bits;
   logic [CW-1:0] fifo_count;
   fetch_entry_t  fifo_head;
   fetch_entry_t  push_entry;
   logic          fifo_empty;
   logic          unused_fifo_full;

   logic          hit;
   logic          bypass;
   logic          miss;
   logic          resp_stale;
   logic          resp_ok;
   logic          push;
   logic          pop;
   logic [CW:0]   occ_after;
   logic          issue_pf;
   logic          issue;
   logic [AW-1:0] issue_addr;

   assign cpu_word             = cpu_addr[AW+1:2];
   assign unused_cpu_addr_bits = ^{cpu_addr[31:AW+2], cpu_addr[1:0]};

   // With a one-cycle SRAM the read outstanding at a miss returns in the miss
   // cycle itself; that response belongs to the flushed stream and is stale.
   assign resp_stale = miss;
   assign resp_ok    = inflight_q && !resp_stale;

   // Hit detection and miss decision.
   always_comb begin
      hit    = cpu_req && !fifo_empty && (fifo_head.addr == ENTRY_AW'(cpu_word));
      bypass = cpu_req && fifo_empty && inflight_q && (if_addr_q == cpu_word);
      miss   = cpu_req && !hit && !bypass;
   end

   assign pop  = hit;
   assign push = inflight_q && !bypass && !miss;

   assign push_entry.addr = ENTRY_AW'(if_addr_q);
   assign push_entry.data = mem_dout;

   // Occupancy as it will stand after this edge, before any new read lands.
   assign occ_after = {1'b0, fifo_count} - (CW + 1)'(pop) + (CW + 1)'(push);

   // Prefetch issue decision and SRAM address selection.
   always_comb begin
      issue_pf   = (state_q == STREAM) && !miss && (occ_after < (CW + 1)'(DEPTH));
      issue      = miss || issue_pf;
      issue_addr = miss ? cpu_word : pf_addr_q;
   end

   // FSM next state and tracking registers for the outstanding read.
   always_comb begin
      state_d    = state_q;
      inflight_d = issue;
      if_addr_d  = if_addr_q;
      pf_addr_d  = pf_addr_q;
      if (issue) begin
         if_addr_d = issue_addr;
      end
      if (miss) begin
         pf_addr_d = cpu_word + AW'(1);
      end else if (issue_pf) begin
         pf_addr_d = pf_addr_q + AW'(1);
      end
      unique case (state_q)
         IDLE:    if (cpu_req) state_d = STREAM;
         STREAM:  state_d = STREAM;
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset also discards any read still outstanding.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         inflight_q <= 1'b0;
         if_addr_q  <= '0;
         pf_addr_q  <= '0;
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
         if_addr_q  <= if_addr_d;
         pf_addr_q  <= pf_addr_d;
      end
   end

   // Outputs are gated by reset so they drop to zero as soon as rst falls.
   always_comb begin
      cpu_valid = rst && (hit || (bypass && resp_ok));
      cpu_instr = '0;
      if (cpu_valid) begin
         cpu_instr = hit ? fifo_head.data : mem_dout;
      end
      mem_read = rst && issue;
      mem_addr = mem_read ? issue_addr : if_addr_q;
   end

   prefetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i        (clk),
      .rst_ni       (rst),
      .push_i       (push),
      .push_entry_i (push_entry),
      .pop_i        (pop),
      .flush_i      (miss),
      .count_o      (fifo_count),
      .head_o       (fifo_head),
      .full_o       (unused_fifo_full),
      .empty_o      (fifo_empty)
   );

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch with a one-cycle SRAM model.
module tb_instr_prefetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req;
   logic [31:0] cpu_addr;
   logic        cpu_valid;
   logic [31:0] cpu_instr;
   logic        mem_read;
   logic [13:0] mem_addr;
   logic [31:0] mem_dout;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   instr_prefetch #(
      .DEPTH (4),
      .AW    (14)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_addr  (cpu_addr),
      .cpu_valid (cpu_valid),
      .cpu_instr (cpu_instr),
      .mem_read  (mem_read),
      .mem_addr  (mem_addr),
      .mem_dout  (mem_dout)
   );

   function automatic logic [31:0] im(input logic [13:0] a);
      return 32'hA500_0000 | {18'd0, a};
   endfunction

   // SRAM: data for the address read at an edge is presented after that edge.
   always @(posedge clk) mem_dout <= mem_read ? im(mem_addr) : 32'hDEAD_BEEF;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive inputs just after a rising edge and sample at the following falling edge.
   task automatic next_cycle(input logic req, input logic [31:0] addr);
      @(posedge clk);
      #1;
      cpu_req  = req;
      cpu_addr = addr;
      @(negedge clk);
   endtask

   function automatic logic [31:0] occ();
      return 32'(dut.u_fifo.count_q);
   endfunction

   initial begin
      rst      = 1'b0;
      cpu_req  = 1'b0;
      cpu_addr = 32'h0;
      #12;
      cpu_req = 1'b1;
      #1;
      chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
      chk("rst_mem_addr", {18'd0, mem_addr}, 32'd0);
      chk("rst_cpu_valid", {31'd0, cpu_valid}, 32'd0);
      chk("rst_cpu_instr", cpu_instr, 32'd0);
      chk("rst_occ", occ(), 32'd0);

      // First fetch after reset: miss then bypass one cycle later.
      @(posedge clk);
      #1;
      rst      = 1'b1;
      cpu_req  = 1'b1;
      cpu_addr = 32'h0;
      @(negedge clk);
      chk("first_mem_read", {31'd0, mem_read}, 32'd1);
      chk("first_mem_addr", {18'd0, mem_addr}, 32'd0);
      chk("first_valid", {31'd0, cpu_valid}, 32'd0);
      next_cycle(1'b1, 32'h0);
      chk("first_hit_valid", {31'd0, cpu_valid}, 32'd1);
      chk("first_hit_instr", cpu_instr, im(14'd0));
      chk("first_pf_addr", {18'd0, mem_addr}, 32'd1);

      // Sequential stream, one fetch per cycle.
      for (int i = 1; i < 8; i++) begin
         next_cycle(1'b1, 32'(4 * i));
         chk("seq_valid", {31'd0, cpu_valid}, 32'd1);
         chk("seq_instr", cpu_instr, im(14'(i)));
         chk("seq_mem_addr", {18'd0, mem_addr}, 32'(i + 1));
         chk("seq_occ_le4", {31'd0, occ() <= 32'd4}, 32'd1);
      end

      // CPU idle: prefetch fills to DEPTH then stops, mem_addr holds.
      for (int k = 0; k < 10; k++) begin
         next_cycle(1'b0, 32'h20);
         chk("idle_valid", {31'd0, cpu_valid}, 32'd0);
         chk("idle_mem_read", {31'd0, mem_read}, (k < 3) ? 32'd1 : 32'd0);
         chk("idle_mem_addr", {18'd0, mem_addr}, (k < 3) ? 32'(9 + k) : 32'd11);
      end
      chk("idle_full_occ", occ(), 32'd4);

      // Resume on the next sequential address: zero-cycle FIFO hit.
      next_cycle(1'b1, 32'h20);
      chk("resume_valid", {31'd0, cpu_valid}, 32'd1);
      chk("resume_instr", cpu_instr, im(14'd8));
      chk("resume_mem_addr", {18'd0, mem_addr}, 32'd12);

      // Jump with 3 entries buffered and a read in flight.
      next_cycle(1'b1, 32'h100);
      chk("jump_occ_before", occ(), 32'd3);
      chk("jump_valid", {31'd0, cpu_valid}, 32'd0);
      chk("jump_instr", cpu_instr, 32'd0);
      chk("jump_mem_read", {31'd0, mem_read}, 32'd1);
      chk("jump_mem_addr", {18'd0, mem_addr}, 32'h40);
      next_cycle(1'b1, 32'h100);
      chk("jump_hit_valid", {31'd0, cpu_valid}, 32'd1);
      chk("jump_hit_instr", cpu_instr, im(14'h40));
      chk("jump_stale_dropped", occ(), 32'd0);
      chk("jump_pf_addr", {18'd0, mem_addr}, 32'h41);

      // Address wrap at the top of the SRAM.
      next_cycle(1'b1, 32'h0000_FFF8);
      chk("wrap_miss_addr", {18'd0, mem_addr}, 32'h3FFE);
      chk("wrap_miss_valid", {31'd0, cpu_valid}, 32'd0);
      next_cycle(1'b1, 32'h0000_FFF8);
      chk("wrap_bypass_instr", cpu_instr, im(14'h3FFE));
      chk("wrap_mem_addr1", {18'd0, mem_addr}, 32'h3FFF);
      next_cycle(1'b0, 32'h0);
      chk("wrap_mem_addr2", {18'd0, mem_addr}, 32'h0000);
      chk("wrap_mem_read2", {31'd0, mem_read}, 32'd1);
      for (int k = 0; k < 3; k++) next_cycle(1'b0, 32'h0);
      next_cycle(1'b1, 32'h0000_FFFC);
      chk("wrap_occ_full", occ(), 32'd4);
      chk("wrap_hit_top_valid", {31'd0, cpu_valid}, 32'd1);
      chk("wrap_hit_top_instr", cpu_instr, im(14'h3FFF));
      chk("wrap_hit_top_mem_addr", {18'd0, mem_addr}, 32'd3);
      next_cycle(1'b1, 32'h0001_0000);
      chk("wrap_hit_w0_valid", {31'd0, cpu_valid}, 32'd1);
      chk("wrap_hit_w0_instr", cpu_instr, im(14'h0));
      chk("wrap_hit_w0_mem_read", {31'd0, mem_read}, 32'd1);
      chk("wrap_hit_w0_mem_addr", {18'd0, mem_addr}, 32'd4);

      // Asynchronous reset with a read being issued.
      rst = 1'b0;
      #1;
      chk("async_mem_read", {31'd0, mem_read}, 32'd0);
      chk("async_mem_addr", {18'd0, mem_addr}, 32'd0);
      chk("async_valid", {31'd0, cpu_valid}, 32'd0);
      chk("async_instr", cpu_instr, 32'd0);
      chk("async_occ", occ(), 32'd0);
      @(posedge clk);
      #1;
      chk("held_rst_mem_read", {31'd0, mem_read}, 32'd0);
      @(posedge clk);
      #1;
      rst      = 1'b1;
      cpu_req  = 1'b1;
      cpu_addr = 32'h0;
      @(negedge clk);
      chk("rerun_mem_read", {31'd0, mem_read}, 32'd1);
      chk("rerun_mem_addr", {18'd0, mem_addr}, 32'd0);
      chk("rerun_valid0", {31'd0, cpu_valid}, 32'd0);
      next_cycle(1'b1, 32'h0);
      chk("rerun_valid1", {31'd0, cpu_valid}, 32'd1);
      chk("rerun_instr1", cpu_instr, im(14'd0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter AW, default 14, SRAM word-address width.
REQ-003 The block SHALL have port clk, input, 1 bit, single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, reset, asynchronous and active-low.
REQ-005 The block SHALL have port cpu_req, input, 1 bit, CPU fetch request this cycle.
REQ-006 The block SHALL have port cpu_addr, input, 32 bits, CPU byte address; only bits [AW+1:2] are used.
REQ-007 The block SHALL have port cpu_valid, output, 1 bit, cpu_instr holds the word at cpu_addr this cycle.
REQ-008 The block SHALL have port cpu_instr, output, 32 bits, instruction word; 0 when cpu_valid=0.
REQ-009 The block SHALL have port mem_read, output, 1 bit, instruction SRAM read enable.
REQ-010 The block SHALL have port mem_addr, output, AW bits, instruction SRAM word address.
REQ-011 The block SHALL have port mem_dout, input, 32 bits, SRAM data, valid the cycle after mem_read=1.

Function
REQ-012 The block SHALL hold up to DEPTH entries {word address, instruction} in FIFO order, plus a prefetch pointer pf_addr (AW bits).
REQ-013 The block SHALL track at most one outstanding SRAM read: flag inflight, address if_addr, stale bit.
REQ-014 The FSM SHALL have states IDLE (after reset, no reads issued) and STREAM (sequential prefetch active).
REQ-015 In IDLE, cpu_req=1 SHALL take the miss path (REQ-019) and move to STREAM; the FSM SHALL never return to IDLE except by reset.
REQ-016 Hit: cpu_req=1, FIFO non-empty and head address == cpu_addr[AW+1:2] SHALL give, combinationally in the same cycle, cpu_valid=1 and cpu_instr=head data, and SHALL pop the head at the clock edge.
REQ-017 Bypass hit: cpu_req=1, FIFO empty, inflight=1, stale=0 and if_addr == cpu_addr[AW+1:2] SHALL give cpu_valid=1, cpu_instr=mem_dout; the response SHALL NOT be pushed.
REQ-018 A non-stale response not consumed by bypass SHALL be pushed to the FIFO tail at the edge; a stale response SHALL be dropped.
REQ-019 Miss: cpu_req=1 with no hit SHALL, in the same cycle, flush the FIFO, set stale on any response arriving next cycle, and drive mem_read=1 with mem_addr=cpu_addr[AW+1:2]; pf_addr SHALL become cpu_addr[AW+1:2]+1.
REQ-020 Miss-to-valid latency SHALL be exactly 1 cycle when cpu_req and cpu_addr are held (bypass on the following cycle).
REQ-021 In STREAM without a miss, mem_read=1 with mem_addr=pf_addr SHALL be issued when (occupancy after this cycle's pop) + (1 if a response is being pushed this cycle) < DEPTH; pf_addr SHALL then increment.
REQ-022 Same-cycle pop and push SHALL keep occupancy constant; push while full SHALL never occur (guaranteed by REQ-021).
REQ-023 pf_addr and mem_addr SHALL wrap modulo 2^AW (0x3FFF+1 -> 0x0000 at AW=14) without flushing.
REQ-024 cpu_req=0 SHALL NOT pop or flush; prefetch continues until full.
REQ-025 When mem_read=0, mem_addr SHALL hold its previous value.

Reset
REQ-026 rst=0 SHALL immediately force: FSM IDLE, FIFO empty, inflight=0, stale=0, pf_addr=0, mem_read=0, mem_addr=0, cpu_valid=0, cpu_instr=0.
REQ-027 Reset asserted with a read outstanding SHALL discard that response; release SHALL resume in IDLE.

Structure
REQ-028 Package fetch_pkg SHALL hold DEPTH and AW defaults, the FSM state enum {IDLE, STREAM}, and the FIFO entry type {addr, data}.
REQ-029 The FIFO SHALL be a sub-module prefetch_fifo (push/pop/flush, count, head, full/empty); hit/miss, issue logic and FSM SHALL stay in instr_prefetch.

Verification
REQ-030 Reset then cpu_req=1, cpu_addr=0x0000_0000 held -> cycle0 mem_read=1 mem_addr=0, cpu_valid=0; cycle1 cpu_valid=1, cpu_instr=IM[0].
REQ-031 Sequential fetch 0x0,0x4,0x8,... every cycle after first hit -> cpu_valid=1 every cycle, occupancy never exceeds 4, mem_addr increments by 1.
REQ-032 cpu_req=0 for 10 cycles during STREAM -> exactly 4 entries plus no further mem_read once full; resumed fetch of next address hits in 0 cycles.
REQ-033 Jump to 0x0000_0100 with 3 entries buffered and a read in flight -> flush, mem_addr=0x40, stale response dropped, cpu_valid=1 one cycle later with IM[0x40].
REQ-034 Fetch from cpu_addr=0x0000_FFF8 sequentially -> mem_addr sequence 0x3FFE, 0x3FFF, 0x0000; cpu_addr 0x0001_0000 hits on word 0 entry.
REQ-035 rst=0 asserted mid-stream with mem_read=1 -> all outputs 0 asynchronously; after release, first cpu_req behaves as REQ-030.
